// File: rtl/writeback_arbiter_if.sv
// rtl/writeback_arbiter_if.sv - requester and writeback-port bundle for writeback_arbiter
interface writeback_arbiter_if #(
    parameter int REQ_NUM      = 6,
    parameter int PORT_NUM     = 2,
    parameter int PHY_ID_WIDTH = 6
);
    logic [REQ_NUM-1:0]                        req_valid;
    logic [REQ_NUM-1:0][PHY_ID_WIDTH-1:0]      req_phy_id;
    logic [REQ_NUM-1:0][31:0]                  req_value;
    logic [REQ_NUM-1:0]                        req_ready;
    logic [PORT_NUM-1:0]                       wb_enable;
    logic [PORT_NUM-1:0][PHY_ID_WIDTH-1:0]     wb_phy_id;
    logic [PORT_NUM-1:0][31:0]                 wb_value;

    // Execution units / register file side
    modport master (
        output req_valid, req_phy_id, req_value,
        input  req_ready, wb_enable, wb_phy_id, wb_value
    );

    // Arbiter side
    modport slave (
        input  req_valid, req_phy_id, req_value,
        output req_ready, wb_enable, wb_phy_id, wb_value
    );
endinterface

// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - per-requester FIFOs with round-robin grant onto PORT_NUM writeback ports
module writeback_arbiter #(
    parameter int REQ_NUM      = 6,
    parameter int PORT_NUM     = 2,
    parameter int PHY_ID_WIDTH = 6,
    parameter int FIFO_DEPTH   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    writeback_arbiter_if.slave    bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int RR_W  = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
    localparam int ENT_W = PHY_ID_WIDTH + 32;

    logic [ENT_W-1:0]                    mem_q [REQ_NUM][FIFO_DEPTH];
    logic [REQ_NUM-1:0][CNT_W-1:0]       count_q, count_d;
    logic [REQ_NUM-1:0][PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [REQ_NUM-1:0][PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [RR_W-1:0]                     rr_q, rr_d;
    logic [PORT_NUM-1:0]                 wb_en_q, wb_en_d;
    logic [PORT_NUM-1:0][PHY_ID_WIDTH-1:0] wb_phy_q, wb_phy_d;
    logic [PORT_NUM-1:0][31:0]           wb_val_q, wb_val_d;
    logic [REQ_NUM-1:0]                  push;
    logic [REQ_NUM-1:0]                  pop;
    int                                  ngrant;
    int                                  idx;

    // Ready comes only from the registered occupancy so requesters never see a pop-dependent path
    always_comb begin
        bus.req_ready = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            bus.req_ready[i] = (count_q[i] != CNT_W'(FIFO_DEPTH));
        end
    end

    assign push = bus.req_valid & bus.req_ready & {REQ_NUM{~flush}};

    // Round-robin scan from rr_q; the k-th non-empty FIFO found feeds port k
    always_comb begin
        pop      = '0;
        wb_en_d  = '0;
        wb_phy_d = '0;
        wb_val_d = '0;
        rr_d     = rr_q;
        ngrant   = 0;
        idx      = 0;
        for (int j = 0; j < REQ_NUM; j++) begin
            idx = (int'(rr_q) + j) % REQ_NUM;
            if (count_q[idx] != '0 && ngrant < PORT_NUM) begin
                pop[idx]        = 1'b1;
                wb_en_d[ngrant] = 1'b1;
                {wb_phy_d[ngrant], wb_val_d[ngrant]} = mem_q[idx][rd_ptr_q[idx]];
                rr_d            = RR_W'((idx + 1) % REQ_NUM);
                ngrant          = ngrant + 1;
            end
        end
    end

    // FIFO bookkeeping; pointers wrap naturally because the depth is a power of two
    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        for (int i = 0; i < REQ_NUM; i++) begin
            wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(push[i]);
            rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(pop[i]);
            count_d[i]  = count_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
        end
    end

    // State registers; flush drops every buffered result and blanks the ports
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            rr_q     <= '0;
            wb_en_q  <= '0;
            wb_phy_q <= '0;
            wb_val_q <= '0;
        end else if (flush) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            rr_q     <= '0;
            wb_en_q  <= '0;
            wb_phy_q <= '0;
            wb_val_q <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            rr_q     <= rr_d;
            wb_en_q  <= wb_en_d;
            wb_phy_q <= wb_phy_d;
            wb_val_q <= wb_val_d;
        end
    end

    // Entry storage needs no reset: stale slots are unreachable once counts are cleared
    always_ff @(posedge clk) begin
        for (int i = 0; i < REQ_NUM; i++) begin
            if (push[i]) begin
                mem_q[i][wr_ptr_q[i]] <= {bus.req_phy_id[i], bus.req_value[i]};
            end
        end
    end

    assign bus.wb_enable = wb_en_q;
    assign bus.wb_phy_id = wb_phy_q;
    assign bus.wb_value  = wb_val_q;
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb/tb_writeback_arbiter.sv - randomized and directed bench for writeback_arbiter
module tb_writeback_arbiter;
    localparam int R = 6;
    localparam int P = 2;
    localparam int W = 6;
    localparam int D = 2;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    always #5 clk = ~clk;

    writeback_arbiter_if #(.REQ_NUM(R), .PORT_NUM(P), .PHY_ID_WIDTH(W)) bus ();

    writeback_arbiter #(.REQ_NUM(R), .PORT_NUM(P), .PHY_ID_WIDTH(W), .FIFO_DEPTH(D)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    logic [W+31:0]            mq [R][$];
    int                       mrr;
    logic [P-1:0]             e_en;
    logic [P-1:0][W-1:0]      e_phy;
    logic [P-1:0][31:0]       e_val;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < R; i++) mq[i].delete();
        mrr   = 0;
        e_en  = '0;
        e_phy = '0;
        e_val = '0;
    endtask

    task automatic check_model();
        logic [R-1:0] er;
        for (int i = 0; i < R; i++) er[i] = (mq[i].size() != D);
        chk("req_ready", 64'(bus.req_ready), 64'(er));
        chk("wb_enable", 64'(bus.wb_enable), 64'(e_en));
        for (int k = 0; k < P; k++) begin
            chk("wb_phy_id", 64'(bus.wb_phy_id[k]), 64'(e_phy[k]));
            chk("wb_value",  64'(bus.wb_value[k]),  64'(e_val[k]));
        end
    endtask

    // Reference behaviour of one rising edge given the inputs currently driven
    task automatic model_edge();
        logic [R-1:0] canp;
        int n;
        int last;
        int base;
        int id;
        if (flush) begin
            model_clear();
            return;
        end
        for (int i = 0; i < R; i++) canp[i] = (mq[i].size() < D);
        n = 0;
        last = 0;
        base = mrr;
        e_en = '0;
        e_phy = '0;
        e_val = '0;
        for (int j = 0; j < R; j++) begin
            id = (base + j) % R;
            if (mq[id].size() > 0 && n < P) begin
                {e_phy[n], e_val[n]} = mq[id].pop_front();
                e_en[n] = 1'b1;
                last = id;
                n++;
            end
        end
        if (n > 0) mrr = (last + 1) % R;
        for (int i = 0; i < R; i++) begin
            if (bus.req_valid[i] && canp[i]) mq[i].push_back({bus.req_phy_id[i], bus.req_value[i]});
        end
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    task automatic idle_inputs();
        bus.req_valid  = '0;
        bus.req_phy_id = '0;
        bus.req_value  = '0;
        flush          = 1'b0;
    endtask

    task automatic drive(input int i, input logic [W-1:0] phy, input logic [31:0] val);
        bus.req_valid[i]  = 1'b1;
        bus.req_phy_id[i] = phy;
        bus.req_value[i]  = val;
    endtask

    task automatic rand_inputs(input int dens);
        for (int i = 0; i < R; i++) begin
            bus.req_valid[i]  = ($urandom_range(99) < dens);
            bus.req_phy_id[i] = W'($urandom);
            bus.req_value[i]  = $urandom;
        end
    endtask

    // Asynchronous reset pulse between edges, with immediate-effect checks
    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_async_wb_enable", 64'(bus.wb_enable), 64'(0));
        chk("rst_async_ready", 64'(bus.req_ready), 64'(6'h3f));
        model_clear();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        check_model();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen_low;
        rst = 1'b1;
        idle_inputs();
        model_clear();
        repeat (2) @(negedge clk);
        chk("reset_wb_enable", 64'(bus.wb_enable), 64'(0));
        chk("reset_ready", 64'(bus.req_ready), 64'(6'h3f));
        chk("reset_phy0", 64'(bus.wb_phy_id[0]), 64'(0));
        chk("reset_val1", 64'(bus.wb_value[1]), 64'(0));
        rst = 1'b0;

        // Single result: two cycles of latency, then idle
        drive(0, 6'd3, 32'h1234);
        cycle();
        idle_inputs();
        cycle();
        chk("single_en", 64'(bus.wb_enable), 64'(2'b01));
        chk("single_phy", 64'(bus.wb_phy_id[0]), 64'(3));
        chk("single_val", 64'(bus.wb_value[0]), 64'(32'h1234));
        cycle();
        chk("single_idle", 64'(bus.wb_enable), 64'(2'b00));

        // Flush restores rr_ptr to 0 before the contention pattern
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("flush_en", 64'(bus.wb_enable), 64'(0));

        for (int i = 0; i < R; i++) drive(i, W'(10 + i), 32'h111 * i);
        cycle();
        idle_inputs();
        cycle();
        chk("cont_c2_en", 64'(bus.wb_enable), 64'(2'b11));
        chk("cont_c2_p0", 64'(bus.wb_phy_id[0]), 64'(10));
        chk("cont_c2_p1", 64'(bus.wb_phy_id[1]), 64'(11));
        cycle();
        chk("cont_c3_p0", 64'(bus.wb_phy_id[0]), 64'(12));
        chk("cont_c3_p1", 64'(bus.wb_phy_id[1]), 64'(13));
        cycle();
        chk("cont_c4_p0", 64'(bus.wb_phy_id[0]), 64'(14));
        chk("cont_c4_v1", 64'(bus.wb_value[1]), 64'(32'h555));
        cycle();
        chk("cont_c5_idle", 64'(bus.wb_enable), 64'(0));

        // Wrap: grant req 4 alone so rr_ptr lands on 5, then reqs 5 and 0 compete
        drive(4, 6'h24, 32'h4);
        cycle();
        idle_inputs();
        cycle();
        chk("wrap_pre_p0", 64'(bus.wb_phy_id[0]), 64'(6'h24));
        drive(5, 6'h25, 32'h5);
        drive(0, 6'h20, 32'h0);
        cycle();
        idle_inputs();
        cycle();
        chk("wrap_p0", 64'(bus.wb_phy_id[0]), 64'(6'h25));
        chk("wrap_p1", 64'(bus.wb_phy_id[1]), 64'(6'h20));
        drive(0, 6'h30, 32'h30);
        drive(1, 6'h31, 32'h31);
        cycle();
        idle_inputs();
        cycle();
        chk("rr_after_wrap_p0", 64'(bus.wb_phy_id[0]), 64'(6'h31));
        chk("rr_after_wrap_p1", 64'(bus.wb_phy_id[1]), 64'(6'h30));

        // Backpressure: lone streaming requester never loses ready
        for (int c = 0; c < 12; c++) begin
            drive(2, W'($urandom), $urandom);
            cycle();
            chk("stream_ready2", 64'(bus.req_ready[2]), 64'(1));
        end
        seen_low = 1'b0;
        for (int c = 0; c < 20; c++) begin
            for (int i = 0; i < R; i++) drive(i, W'($urandom), $urandom);
            cycle();
            if (!bus.req_ready[2]) seen_low = 1'b1;
        end
        chk("contended_ready2_drops", 64'(seen_low), 64'(1));
        idle_inputs();
        repeat (6) cycle();

        // Flush with buffered data and a flush-cycle request
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < R; i++) drive(i, W'($urandom), $urandom);
            cycle();
        end
        idle_inputs();
        flush = 1'b1;
        drive(1, 6'h3f, 32'hdead);
        cycle();
        idle_inputs();
        chk("flush_wb_enable", 64'(bus.wb_enable), 64'(0));
        chk("flush_ready", 64'(bus.req_ready), 64'(6'h3f));
        for (int c = 0; c < 5; c++) begin
            cycle();
            chk("post_flush_idle", 64'(bus.wb_enable), 64'(0));
        end

        // Reset mid-run with full FIFOs
        for (int c = 0; c < 5; c++) begin
            for (int i = 0; i < R; i++) drive(i, W'($urandom), $urandom);
            cycle();
        end
        async_reset();
        for (int c = 0; c < 4; c++) begin
            cycle();
            chk("post_rst_idle", 64'(bus.wb_enable), 64'(0));
        end

        // Randomized traffic with varying load, flushes and resets
        for (int c = 0; c < 3000; c++) begin
            rand_inputs((c / 250) % 2 == 0 ? 90 : 30);
            flush = ($urandom_range(63) == 0);
            if ($urandom_range(299) == 0) begin
                async_reset();
            end else begin
                cycle();
            end
        end
        idle_inputs();
        repeat (8) cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 SHALL have parameter REQ_NUM, default 6: number of execution-unit feedback requesters (ALU, BRU, CSR, DIV, LSU, MUL order).
REQ-002 SHALL have parameter PORT_NUM, default 2: number of physical-register writeback ports, 1 <= PORT_NUM <= REQ_NUM.
REQ-003 SHALL have parameter PHY_ID_WIDTH, default 6: physical register id width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 2: per-requester buffer entries, power of two, >= 2.
REQ-005 SHALL have port clk, input, 1: the single clock; all state on rising edge.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-007 SHALL have port flush, input, 1: pipeline flush, discards all buffered results.
REQ-008 SHALL have port req_valid, input, REQ_NUM: requester i presents a result.
REQ-009 SHALL have port req_phy_id, input, REQ_NUM x PHY_ID_WIDTH: destination physical register id.
REQ-010 SHALL have port req_value, input, REQ_NUM x 32: result value.
REQ-011 SHALL have port req_ready, output, REQ_NUM: requester i's buffer can accept this cycle.
REQ-012 SHALL have port wb_enable, output, PORT_NUM: writeback port k carries a valid result.
REQ-013 SHALL have port wb_phy_id, output, PORT_NUM x PHY_ID_WIDTH: port k destination id.
REQ-014 SHALL have port wb_value, output, PORT_NUM x 32: port k value.

Function
REQ-015 SHALL keep one FIFO per requester; push when req_valid[i] && req_ready[i] && !flush.
REQ-016 SHALL drive req_ready[i] = (registered count[i] != FIFO_DEPTH); no dependence on same-cycle pop.
REQ-017 SHALL, each cycle, select up to PORT_NUM non-empty FIFOs scanning indices rr_ptr, rr_ptr+1, ... mod REQ_NUM; the k-th selected drives port k.
REQ-018 SHALL pop exactly one entry from each selected FIFO; at most one pop per requester per cycle.
REQ-019 SHALL register the selected heads into wb_enable/wb_phy_id/wb_value; unused ports get enable=0, phy_id=0, value=0.
REQ-020 SHALL have latency: handshake in cycle N -> earliest wb_enable in cycle N+2; no bypass path.
REQ-021 SHALL advance rr_ptr to (last selected index + 1) mod REQ_NUM when >=1 grant; unchanged when none.
REQ-022 SHALL preserve per-requester order; cross-requester order is unspecified.
REQ-023 SHALL, on push and pop of the same FIFO in one cycle, leave count unchanged; pointers wrap mod FIFO_DEPTH.
REQ-024 SHALL guarantee any non-empty FIFO is granted within ceil(REQ_NUM/PORT_NUM) cycles.
REQ-025 SHALL, with flush high at an edge: clear all counts/pointers, set rr_ptr=0, load wb outputs with zeros, perform no pop or push; flush wins over all other events.

Reset
REQ-026 SHALL, while rst high: counts=0, FIFO pointers=0, rr_ptr=0, wb_enable=0, wb_phy_id=0, wb_value=0, req_ready all 1.
REQ-027 SHALL discard in-flight data on rst asserted mid-operation; first grant possible in 2nd cycle after a push following rst release.

Verification
REQ-028 Single: req 0 valid cycle 5, phy_id=3, value=0x1234 -> cycle 7 wb_enable=01, wb_phy_id[0]=3, wb_value[0]=0x1234; cycle 8 wb_enable=00.
REQ-029 Contention: reqs 0..5 each push one result in cycle 0, rr_ptr=0 -> cycle 2 ports get req 0,1; cycle 3 req 2,3; cycle 4 req 4,5; cycle 5 idle.
REQ-030 Backpressure: req 2 valid every cycle, others idle, PORT_NUM=2 -> one grant per cycle, req_ready[2] never drops after reset; then hold output pops off by forcing 5 competing requesters -> req_ready[2]=0 when count reaches 2, no data lost or reordered.
REQ-031 Wrap/fairness: rr_ptr=5, reqs 5 and 0 non-empty -> port0=req 5, port1=req 0, rr_ptr becomes 1.
REQ-032 Flush: FIFOs holding 7 entries total, flush in cycle N with req_valid[1]=1 -> cycle N+1 wb_enable=00, all req_ready=1, no later output of any pre-flush or flush-cycle data.
REQ-033 Reset mid-run: rst pulsed asynchronously between edges with full FIFOs -> wb_enable=00 immediately, all req_ready=1, no stale results after release.
